mbist_pattern_checker: RTL
==========================

Name: mbist_pattern_checker

Overview:
- Read-side counterpart of the MBIST test-pattern generator.
- Takes each memory read-back beat and encodes the observed byte into its 3-bit pattern code.
- Compares that code against the expected code and keeps per-session failure state for the BIST controller: error count, sticky fail, first-fail log.
- Sits between the memory read port and the controller's result registers.

Parameters:
ADDR_W, 8, width of read address
CNT_W, 16, width of error counter (saturating)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
clear  input  1  synchronous session clear (counters/logs to reset values)
rd_valid  input  1  read-back beat valid this cycle
rd_addr  input  ADDR_W  address of beat
rd_data  input  8  data read from memory
exp_q  input  3  expected pattern code for this beat
cmp_valid  output  1  comparison result valid (1 cycle after rd_valid)
obs_q  output  3  encoded code of observed data (3'b111 if no match)
obs_match  output  1  observed data equals one of the six legal patterns
cmp_fail  output  1  this beat failed
fail_sticky  output  1  any failure since last clear/reset
illegal_exp  output  1  sticky: exp_q of 6 or 7 seen on a valid beat
err_count  output  CNT_W  failing beats since clear, saturating
first_fail_valid  output  1  first-fail log holds data
first_fail_addr  output  ADDR_W  address of first failing beat
first_fail_data  output  8  rd_data of first failing beat
first_fail_exp_q  output  3  exp_q of first failing beat

Behaviour:
- Pattern encoding (combinational, registered at output):
  - 8'hAA->0, 8'h55->1, 8'hF0->2, 8'h0F->3, 8'h00->4, 8'hFF->5.
  - Any other byte: obs_q=3'b111, obs_match=0.
- Beat fails when any of these holds: exp_q>5, obs_match=0, obs_q!=exp_q.
- Latency 1: a beat with rd_valid=1 at edge N gives cmp_valid=1 with obs_q, obs_match, cmp_fail during cycle N+1. Back-to-back beats every cycle are supported; there is no backpressure.
- When rd_valid=0:
  - cmp_valid=0 and cmp_fail=0 next cycle.
  - obs_q and obs_match hold their last values.
- On a failing beat, at the same edge that asserts cmp_fail:
  - err_count increments, saturating at all-ones.
  - fail_sticky is set.
  - If first_fail_valid=0: capture addr, data and exp_q, and set first_fail_valid.
  - Later failures never overwrite the first-fail log.
- illegal_exp is set on any valid beat with exp_q in {6,7}; that beat also counts as a fail.
- Two-state session FSM:
  - States: IDLE_CLEAN (no fail logged) and FAILED (first_fail_valid=1).
  - IDLE_CLEAN->FAILED on the first failing beat.
  - FAILED->IDLE_CLEAN only on clear or rst.
- Reset values, also applied by clear:
  - cmp_valid=0, cmp_fail=0, obs_q=3'b111, obs_match=0.
  - fail_sticky=0, illegal_exp=0, err_count=0.
  - first_fail_valid=0, first_fail_addr=0, first_fail_data=0, first_fail_exp_q=0.
- Priority is rst > clear > rd_valid. A beat presented in the same cycle as clear is discarded: no count, and cmp_valid=0 next cycle.
- Counter saturation: at err_count = 2^CNT_W-1, further fails leave the count unchanged; fail_sticky stays set.

Decomposition:
- Package mbist_pkg holds the pattern constants:
  - PAT_CHECKER=8'hAA, PAT_INV_CHECKER=8'h55, PAT_HI_NIB=8'hF0, PAT_LO_NIB=8'h0F, PAT_ZEROS=8'h00, PAT_ONES=8'hFF.
  - Code localparams 3'd0..3'd5 and CODE_NONE=3'b111.
  - The pattern-code typedef (3-bit).
- The generator side is re-pointed to the same package.
- One natural sub-module: pattern_encoder (pure combinational, rd_data -> obs_q/obs_match). The top level holds the pipeline register, counter, log and FSM.

Test Plan:
- Sweep codes 0..5 with matching data (AA,55,F0,0F,00,FF) on consecutive cycles -> cmp_valid each cycle one cycle later, obs_q=0..5, cmp_fail=0, err_count=0, fail_sticky=0.
- Beat at addr 8'h12 with data 8'hAB, exp_q=0, then beat at addr 8'h20 with data 8'h00, exp_q=5 -> obs_q=7/obs_match=0 then obs_q=4. cmp_fail on both, err_count=2, first_fail_addr=8'h12, first_fail_data=8'hAB, first_fail_exp_q=0.
- Beat with exp_q=6 and data 8'hAA -> cmp_fail=1, illegal_exp=1, err_count=1, obs_q=0.
- With CNT_W=4, drive 20 failing beats -> err_count saturates at 15, fail_sticky=1, first-fail log unchanged after beat 1.
- Failing beat asserted together with clear -> cmp_valid=0 next cycle, all logs at reset values. A following failing beat is logged as first fail.
- Assert rst mid-stream with first_fail_valid=1 and err_count=3 -> next cycle all outputs at reset values. The beat in the rst cycle is ignored.

Source files
------------

// File: rtl/mbist_pkg.sv
// mbist_pkg: pattern bytes and 3-bit pattern codes shared by the MBIST
// pattern generator and the read-side pattern checker.
`default_nettype none

package mbist_pkg;

  typedef logic [2:0] pat_code_t;

  localparam logic [7:0] PAT_CHECKER     = 8'hAA;
  localparam logic [7:0] PAT_INV_CHECKER = 8'h55;
  localparam logic [7:0] PAT_HI_NIB      = 8'hF0;
  localparam logic [7:0] PAT_LO_NIB      = 8'h0F;
  localparam logic [7:0] PAT_ZEROS       = 8'h00;
  localparam logic [7:0] PAT_ONES        = 8'hFF;

  localparam pat_code_t CODE_CHECKER     = 3'd0;
  localparam pat_code_t CODE_INV_CHECKER = 3'd1;
  localparam pat_code_t CODE_HI_NIB      = 3'd2;
  localparam pat_code_t CODE_LO_NIB      = 3'd3;
  localparam pat_code_t CODE_ZEROS       = 3'd4;
  localparam pat_code_t CODE_ONES        = 3'd5;
  localparam pat_code_t CODE_NONE        = 3'b111;

  // Highest code that names a real pattern; 6 and 7 are never legal expectations.
  localparam pat_code_t CODE_MAX_LEGAL   = CODE_ONES;

endpackage

`default_nettype wire

// File: rtl/pattern_encoder.sv
// pattern_encoder: combinational map from a read-back byte to its pattern code.
`default_nettype none

module pattern_encoder
  import mbist_pkg::*;
(
  input  logic [7:0] data,
  output pat_code_t  code,
  output logic       match
);

  always_comb begin
    code  = CODE_NONE;
    match = 1'b1;
    case (data)
      PAT_CHECKER:     code = CODE_CHECKER;
      PAT_INV_CHECKER: code = CODE_INV_CHECKER;
      PAT_HI_NIB:      code = CODE_HI_NIB;
      PAT_LO_NIB:      code = CODE_LO_NIB;
      PAT_ZEROS:       code = CODE_ZEROS;
      PAT_ONES:        code = CODE_ONES;
      default: begin
        code  = CODE_NONE;
        match = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mbist_pattern_checker.sv
// mbist_pattern_checker: compares encoded read-back beats against the expected
// pattern code and keeps per-session failure state (count, sticky, first-fail log).
`default_nettype none

module mbist_pattern_checker
  import mbist_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  input  logic [2:0]        exp_q,
  output logic              cmp_valid,
  output logic [2:0]        obs_q,
  output logic              obs_match,
  output logic              cmp_fail,
  output logic              fail_sticky,
  output logic              illegal_exp,
  output logic [CNT_W-1:0]  err_count,
  output logic              first_fail_valid,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic [7:0]        first_fail_data,
  output logic [2:0]        first_fail_exp_q
);

  typedef enum logic [0:0] {
    IDLE_CLEAN = 1'b0,
    FAILED     = 1'b1
  } state_t;

  state_t    state;
  pat_code_t enc_code;
  logic      enc_match;
  logic      exp_illegal;
  logic      beat_fail;

  pattern_encoder u_encoder (
    .data  (rd_data),
    .code  (enc_code),
    .match (enc_match)
  );

  assign exp_illegal = (exp_q > CODE_MAX_LEGAL);
  assign beat_fail   = exp_illegal || !enc_match || (enc_code != exp_q);

  // The first-fail log is valid exactly while the session sits in FAILED.
  assign first_fail_valid = (state == FAILED);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state            <= IDLE_CLEAN;
      cmp_valid        <= 1'b0;
      cmp_fail         <= 1'b0;
      obs_q            <= CODE_NONE;
      obs_match        <= 1'b0;
      fail_sticky      <= 1'b0;
      illegal_exp      <= 1'b0;
      err_count        <= '0;
      first_fail_addr  <= '0;
      first_fail_data  <= '0;
      first_fail_exp_q <= '0;
    end else begin
      cmp_valid <= rd_valid;
      cmp_fail  <= rd_valid && beat_fail;
      if (rd_valid) begin
        obs_q     <= enc_code;
        obs_match <= enc_match;
        if (exp_illegal) begin
          illegal_exp <= 1'b1;
        end
        if (beat_fail) begin
          fail_sticky <= 1'b1;
          if (err_count != {CNT_W{1'b1}}) begin
            err_count <= err_count + 1'b1;
          end
          case (state)
            IDLE_CLEAN: begin
              first_fail_addr  <= rd_addr;
              first_fail_data  <= rd_data;
              first_fail_exp_q <= exp_q;
              state            <= FAILED;
            end
            default: state <= FAILED;
          endcase
        end
      end
    end
  end

endmodule

`default_nettype wire
